// File: rtl/dsp_pkg.sv
// Shared DSP definitions: coefficient address map helpers and the
// coefficient-loader FSM state encoding.
package dsp_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } loader_state_e;

    // Address map of an order-n IIR coefficient set: b0..bn, then a1..an.
    localparam int B_BASE = 0;

    function automatic int a_base(input int n);
        return n + 1;
    endfunction

    function automatic int last_addr(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/iir_coeff_loader.sv
// Double-buffered IIR coefficient loader: writes land in a shadow bank and
// are transferred to the active bank atomically on a sample boundary.
module iir_coeff_loader
    import dsp_pkg::*;
#(
    parameter int                     N           = 2,
    parameter int                     COEFF_WIDTH = 16,
    parameter int                     ADDR_WIDTH  = 3,
    parameter logic [COEFF_WIDTH-1:0] RESET_B0    = 16'h4000
) (
    input  logic                         rst_n,
    input  logic                         clk,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [COEFF_WIDTH-1:0]       wr_data,
    input  logic                         commit,
    input  logic                         abort,
    input  logic                         sample_strobe,
    output logic                         pending,
    output logic                         applied,
    output logic                         addr_err,
    output logic [COEFF_WIDTH*(N+1)-1:0] packed_b_coeffs,
    output logic [COEFF_WIDTH*N-1:0]     packed_a_coeffs
);

    localparam int                    NUM_COEFFS = last_addr(N) + 1;
    localparam int                    A_BASE     = a_base(N);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(last_addr(N));

    typedef logic [COEFF_WIDTH-1:0] coeff_t;

    coeff_t        shadow_q [NUM_COEFFS];
    coeff_t        active_q [NUM_COEFFS];
    loader_state_e state_q, state_d;
    logic          applied_q, addr_err_q, addr_err_d;
    logic          do_shadow_write, do_restore, do_apply;
    logic          wr_fire, addr_ok;

    assign wr_ready = (state_q == ST_IDLE);
    assign pending  = (state_q == ST_PENDING);
    assign applied  = applied_q;
    assign addr_err = addr_err_q;
    assign wr_fire  = wr_valid && wr_ready;
    assign addr_ok  = (wr_addr <= LAST_ADDR);

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d         = state_q;
        do_shadow_write = 1'b0;
        do_restore      = 1'b0;
        do_apply        = 1'b0;
        addr_err_d      = addr_err_q;
        case (state_q)
            ST_IDLE: begin
                if (abort) begin
                    do_restore = 1'b1;
                end else begin
                    do_shadow_write = wr_fire && addr_ok;
                    if (commit) begin
                        state_d    = ST_PENDING;
                        addr_err_d = 1'b0;
                    end
                end
                // A bad address is flagged even if abort discards the write.
                if (wr_fire && !addr_ok) addr_err_d = 1'b1;
            end
            ST_PENDING: begin
                if (abort) begin
                    do_restore = 1'b1;
                    state_d    = ST_IDLE;
                end else if (sample_strobe) begin
                    do_apply = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values; that is what makes the bank swap atomic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            applied_q  <= 1'b0;
            addr_err_q <= 1'b0;
            // NOTE: both banks are reset explicitly; they are small flop arrays
            // feeding the filter directly, so they must never power up as X.
            for (int i = 0; i < NUM_COEFFS; i++) begin
                shadow_q[i] <= (i == B_BASE) ? RESET_B0 : '0;
                active_q[i] <= (i == B_BASE) ? RESET_B0 : '0;
            end
        end else begin
            state_q    <= state_d;
            applied_q  <= do_apply;
            addr_err_q <= addr_err_d;
            for (int i = 0; i < NUM_COEFFS; i++) begin
                if (do_restore) begin
                    shadow_q[i] <= active_q[i];
                end else if (do_shadow_write && wr_addr == ADDR_WIDTH'(i)) begin
                    shadow_q[i] <= wr_data;
                end
                if (do_apply) active_q[i] <= shadow_q[i];
            end
        end
    end

    for (genvar i = 0; i <= N; i++) begin : g_pack_b
        assign packed_b_coeffs[i*COEFF_WIDTH +: COEFF_WIDTH] = active_q[B_BASE+i];
    end

    for (genvar i = 1; i <= N; i++) begin : g_pack_a
        assign packed_a_coeffs[(i-1)*COEFF_WIDTH +: COEFF_WIDTH] = active_q[A_BASE+i-1];
    end

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Directed self-checking bench for iir_coeff_loader (N=2, 16-bit coefficients).
module tb_iir_coeff_loader;

    logic        rst_n, clk;
    logic        wr_valid, wr_ready;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        commit, abort, sample_strobe;
    logic        pending, applied, addr_err;
    logic [47:0] packed_b_coeffs;
    logic [31:0] packed_a_coeffs;

    int pass_cnt  = 0;
    int total_cnt = 0;

    iir_coeff_loader dut (
        .rst_n           (rst_n),
        .clk             (clk),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .commit          (commit),
        .abort           (abort),
        .sample_strobe   (sample_strobe),
        .pending         (pending),
        .applied         (applied),
        .addr_err        (addr_err),
        .packed_b_coeffs (packed_b_coeffs),
        .packed_a_coeffs (packed_a_coeffs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_valid      = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        commit        = 1'b0;
        abort         = 1'b0;
        sample_strobe = 1'b0;
    endtask

    task automatic write(input logic [2:0] addr, input logic [15:0] data);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        tick();
        clear_inputs();
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic chk_banks(input string name, input logic [47:0] exp_b, input logic [31:0] exp_a);
        total_cnt++;
        if (packed_b_coeffs !== exp_b || packed_a_coeffs !== exp_a)
            $display("FAIL %s: got b=%h a=%h expected b=%h a=%h",
                     name, packed_b_coeffs, packed_a_coeffs, exp_b, exp_a);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
        chk_banks("reset_banks", 48'h0000_0000_4000, 32'h0);
        chk_bit("reset_wr_ready", wr_ready, 1'b1);
        chk_bit("reset_pending", pending, 1'b0);
        chk_bit("reset_applied", applied, 1'b0);
        chk_bit("reset_addr_err", addr_err, 1'b0);
    endtask

    task automatic test_commit_strobe();
        write(3'd1, 16'h1234);
        write(3'd4, 16'hF000);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk_bit("commit_pending", pending, 1'b1);
        chk_bit("commit_wr_ready", wr_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_banks("commit_wait_unchanged", 48'h0000_0000_4000, 32'h0);
            tick();
        end
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        chk_banks("strobe_applied_banks", 48'h0000_1234_4000, 32'hF000_0000);
        chk_bit("strobe_applied_pulse", applied, 1'b1);
        chk_bit("strobe_pending_low", pending, 1'b0);
        tick();
        chk_bit("applied_one_cycle", applied, 1'b0);
    endtask

    task automatic test_strobe_idle();
        write(3'd0, 16'h1111);
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        chk_banks("idle_strobe_no_effect", 48'h0000_1234_4000, 32'hF000_0000);
        chk_bit("idle_strobe_no_applied", applied, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_addr_err();
        write(3'd7, 16'hAAAA);
        chk_bit("bad_addr_err_set", addr_err, 1'b1);
        chk_banks("bad_addr_active_same", 48'h0000_1234_4000, 32'hF000_0000);
        // Bad write together with commit keeps the flag set.
        wr_valid = 1'b1;
        wr_addr  = 3'd5;
        wr_data  = 16'hBBBB;
        commit   = 1'b1;
        tick();
        clear_inputs();
        chk_bit("bad_with_commit_keeps_err", addr_err, 1'b1);
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        chk_banks("bad_addr_shadow_same", 48'h0000_1234_4000, 32'hF000_0000);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk_bit("commit_clears_addr_err", addr_err, 1'b0);
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
    endtask

    task automatic test_pending_abort();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        write(3'd0, 16'h7FFF);
        chk_bit("pending_wr_ready_low", wr_ready, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_bit("abort_to_idle", pending, 1'b0);
        chk_bit("abort_no_applied", applied, 1'b0);
        chk_banks("abort_active_same", 48'h0000_1234_4000, 32'hF000_0000);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        chk_banks("pending_write_ignored", 48'h0000_1234_4000, 32'hF000_0000);
    endtask

    task automatic test_abort_idle();
        write(3'd3, 16'h2222);
        // Abort with same-cycle write and commit: abort wins on both.
        wr_valid = 1'b1;
        wr_addr  = 3'd0;
        wr_data  = 16'h7FFF;
        commit   = 1'b1;
        abort    = 1'b1;
        tick();
        clear_inputs();
        chk_bit("abort_beats_commit", pending, 1'b0);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        chk_banks("abort_discards_shadow", 48'h0000_1234_4000, 32'hF000_0000);
    endtask

    task automatic test_commit_with_write();
        wr_valid = 1'b1;
        wr_addr  = 3'd2;
        wr_data  = 16'h0101;
        commit   = 1'b1;
        tick();
        clear_inputs();
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        chk_banks("commit_same_cycle_write", 48'h0101_1234_4000, 32'hF000_0000);
    endtask

    task automatic test_reset_pending();
        write(3'd1, 16'h5555);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk_bit("pre_reset_pending", pending, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_bit("async_reset_pending", pending, 1'b0);
        chk_banks("async_reset_banks", 48'h0000_0000_4000, 32'h0);
        tick();
        rst_n = 1'b1;
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        chk_bit("reset_drop_no_applied", applied, 1'b0);
        tick();
        chk_bit("reset_drop_no_applied_late", applied, 1'b0);
        chk_banks("reset_drop_banks", 48'h0000_0000_4000, 32'h0);
    endtask

    initial begin
        test_reset();
        test_commit_strobe();
        test_strobe_idle();
        test_addr_err();
        test_pending_abort();
        test_abort_idle();
        test_commit_with_write();
        test_reset_pending();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/iir_coeff_loader.md
IIR_COEFF_LOADER -- requirements
Module: iir_coeff_loader

Interface
REQ-001 SHALL have parameter N, default 2, filter order (number of feedback coefficients).
REQ-002 SHALL have parameter COEFF_WIDTH, default 16, coefficient width (signed, two's complement).
REQ-003 SHALL have parameter ADDR_WIDTH, default 3, coefficient address width (2^ADDR_WIDTH >= 2N+1).
REQ-004 SHALL have parameter RESET_B0, default 16'h4000, reset value of b0 (unity at Q14); all other coefficients reset to 0.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port wr_valid  input  1  coefficient write request.
REQ-008 SHALL have port wr_ready  output  1  write accepted when wr_valid && wr_ready.
REQ-009 SHALL have port wr_addr  input  ADDR_WIDTH  0..N = b0..bN, N+1..2N = a1..aN (negated feedback coeffs).
REQ-010 SHALL have port wr_data  input  COEFF_WIDTH  coefficient value.
REQ-011 SHALL have port commit  input  1  request transfer of shadow bank to active bank.
REQ-012 SHALL have port abort  input  1  discard shadow edits (shadow := active).
REQ-013 SHALL have port sample_strobe  input  1  one-cycle pulse marking the filter sample boundary.
REQ-014 SHALL have port pending  output  1  commit accepted, awaiting sample_strobe.
REQ-015 SHALL have port applied  output  1  one-cycle pulse after active bank update.
REQ-016 SHALL have port addr_err  output  1  sticky: write to address > 2N attempted.
REQ-017 SHALL have port packed_b_coeffs  output  COEFF_WIDTH*(N+1)  active b_i at bits [i*COEFF_WIDTH +: COEFF_WIDTH].
REQ-018 SHALL have port packed_a_coeffs  output  COEFF_WIDTH*N  active a_i at bits [(i-1)*COEFF_WIDTH +: COEFF_WIDTH].

Function
REQ-019 SHALL hold two register banks of 2N+1 coefficients: shadow (writable) and active (drives packed outputs directly from flops, no combinational path from inputs).
REQ-020 SHALL implement FSM states IDLE and PENDING; wr_ready = (state == IDLE); pending = (state == PENDING).
REQ-021 In IDLE, an accepted write with wr_addr <= 2N SHALL update the addressed shadow entry at that edge; wr_addr > 2N SHALL leave shadow unchanged and set addr_err.
REQ-022 In IDLE, commit SHALL move to PENDING; a write accepted in the same cycle SHALL be included in the committed bank.
REQ-023 In IDLE, abort SHALL copy active to shadow; abort with a same-cycle write SHALL win (write discarded); abort with commit SHALL win (stay IDLE).
REQ-024 In PENDING, wr_valid and commit SHALL be ignored; abort SHALL return to IDLE with shadow := active and no active update.
REQ-025 In PENDING, sample_strobe (without abort) SHALL copy shadow to active at that edge, return to IDLE, and assert applied for exactly the following cycle.
REQ-026 sample_strobe in IDLE SHALL have no effect; active bank SHALL change only per REQ-025 or reset.
REQ-027 All 2N+1 active coefficients SHALL change on the same edge (no partially updated set ever visible).
REQ-028 addr_err SHALL clear on the edge where a commit is accepted in IDLE; a same-cycle bad write SHALL keep it set.
REQ-029 Coefficients SHALL be stored verbatim; no scaling, saturation or sign manipulation.

Reset
REQ-030 On rst_n low, asynchronously: state IDLE, pending 0, applied 0, addr_err 0, wr_ready 1 after release, both banks b0 = RESET_B0, all others 0.
REQ-031 Reset asserted while PENDING SHALL drop the pending commit; no applied pulse follows.

Structure
REQ-032 Address map constants (B_BASE=0, A_BASE=N+1, LAST=2N) and FSM state encodings SHALL live in the shared dsp package.
REQ-033 SHALL be a single module with no sub-modules; outputs connect directly to the IIR filter coefficient inputs.

Verification
REQ-034 Reset: release rst_n -> packed_b_coeffs = 48'h0000_0000_4000, packed_a_coeffs = 32'h0, wr_ready 1.
REQ-035 Write b1=16'h1234, a2=16'hF000, commit; strobe 3 cycles later -> outputs unchanged until strobe edge, then b1/a2 fields updated, applied high one cycle, pending low.
REQ-036 Write addr 7 with 16'hAAAA -> addr_err 1, banks unchanged; next commit clears addr_err.
REQ-037 In PENDING, write b0=16'h7FFF then abort -> wr_ready low during PENDING, no active change, b0 still 16'h4000 after a later commit+strobe.
REQ-038 Commit with write b2=16'h0101 same cycle, then strobe -> b2 field = 16'h0101 in active bank.
REQ-039 Assert rst_n low while PENDING, then strobe -> applied never pulses, outputs at reset values.
